// File: rtl/pcm_fifo_feeder.sv
// PCM FIFO refill controller: bursts VRAM sample bytes into the PCM FIFO on almost-empty,
// sharing the FIFO write port with CPU direct writes (CPU always wins).
module pcm_fifo_feeder #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned BURST  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              fifo_reset,
    input  logic [7:0]        cpu_wrdata,
    input  logic              cpu_write,
    input  logic              fifo_full,
    input  logic              fifo_almost_empty,
    output logic [7:0]        fifo_wrdata,
    output logic              fifo_write,
    output logic              vram_req,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rddata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = $clog2(BURST + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWrite} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        hold_q, hold_d;
    logic              running_q, running_d;
    logic              enable_q, enable_d;
    logic              abort_q, abort_d;
    logic              vram_req_q, vram_req_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              feed_wr;
    logic              ended;
    logic              live;

    // Dropping enable takes effect in the same cycle so an in-flight byte is never written.
    assign live = running_q && enable;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        running_d   = running_q;
        enable_d    = enable;
        abort_d     = abort_q;
        vram_req_d  = vram_req_q;
        vram_addr_d = vram_addr_q;
        done_d      = 1'b0;
        feed_wr     = 1'b0;
        ended       = 1'b0;

        if (enable && !enable_q) begin
            addr_d    = start_addr;
            running_d = 1'b1;
        end else if (!enable) begin
            running_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (live && fifo_almost_empty && !fifo_full && !fifo_reset) begin
                    state_d     = StReq;
                    cnt_d       = '0;
                    abort_d     = 1'b0;
                    vram_req_d  = 1'b1;
                    vram_addr_d = addr_q;
                end
            end
            StReq: begin
                // The handshake is always completed; an abort only discards the data.
                if (!live || fifo_reset) abort_d = 1'b1;
                if (vram_ack) begin
                    vram_req_d = 1'b0;
                    if (abort_q || !live || fifo_reset) begin
                        state_d = StIdle;
                    end else begin
                        hold_d  = vram_rddata;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (!live || fifo_reset) begin
                    hold_d  = '0;
                    state_d = StIdle;
                end else if (!cpu_write && !fifo_full) begin
                    feed_wr = 1'b1;
                    cnt_d   = cnt_q + CntW'(1);
                    if (addr_q == end_addr) begin
                        if (loop_en) begin
                            addr_d = start_addr;
                        end else begin
                            running_d = 1'b0;
                            done_d    = 1'b1;
                            ended     = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (cnt_q == CntW'(BURST - 1) || ended || fifo_full) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StReq;
                        abort_d     = 1'b0;
                        vram_req_d  = 1'b1;
                        vram_addr_d = addr_d;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            running_q   <= 1'b0;
            enable_q    <= 1'b0;
            abort_q     <= 1'b0;
            vram_req_q  <= 1'b0;
            vram_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            running_q   <= running_d;
            enable_q    <= enable_d;
            abort_q     <= abort_d;
            vram_req_q  <= vram_req_d;
            vram_addr_q <= vram_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fifo_write  = cpu_write | feed_wr;
    assign fifo_wrdata = cpu_write ? cpu_wrdata : hold_q;
    assign vram_req    = vram_req_q;
    assign vram_addr   = vram_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pcm_fifo_feeder.sv
// Scoreboard bench for pcm_fifo_feeder: a VRAM responder with programmable latency and
// expected-byte queues for the stream and CPU paths, popped as FIFO writes appear.
module tb_pcm_fifo_feeder;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          loop_en;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          fifo_reset;
    logic [7:0]    cpu_wrdata;
    logic          cpu_write;
    logic          fifo_full;
    logic          fifo_almost_empty;
    logic [7:0]    fifo_wrdata;
    logic          fifo_write;
    logic          vram_req;
    logic [AW-1:0] vram_addr;
    logic          vram_ack = 1'b0;
    logic [7:0]    vram_rddata = 8'h00;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    int lat = 2;
    int vcnt = 0;
    int done_cnt = 0;
    int done_base;

    logic [AW-1:0] exp_q[$];
    logic [7:0]    cpu_q[$];

    pcm_fifo_feeder #(.ADDR_W(AW), .BURST(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .loop_en           (loop_en),
        .start_addr        (start_addr),
        .end_addr          (end_addr),
        .fifo_reset        (fifo_reset),
        .cpu_wrdata        (cpu_wrdata),
        .cpu_write         (cpu_write),
        .fifo_full         (fifo_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_wrdata       (fifo_wrdata),
        .fifo_write        (fifo_write),
        .vram_req          (vram_req),
        .vram_addr         (vram_addr),
        .vram_ack          (vram_ack),
        .vram_rddata       (vram_rddata),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vdata(input logic [AW-1:0] a);
        return a[7:0] ^ {1'b0, a[16:10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // VRAM responder: acks after lat request cycles with address-derived data.
    always begin
        @(posedge clk);
        #1;
        if (vram_req === 1'b1) begin
            if (vcnt >= lat) begin
                vram_ack    = 1'b1;
                vram_rddata = vdata(vram_addr);
                vcnt        = 0;
            end else begin
                vram_ack = 1'b0;
                vcnt++;
            end
        end else begin
            vram_ack = 1'b0;
            vcnt     = 0;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (cpu_write) begin
            check("cpu_passthru_we", 32'(fifo_write), 32'd1);
            if (cpu_q.size() != 0) check("cpu_data", 32'(fifo_wrdata), 32'(cpu_q.pop_front()));
        end else if (fifo_write === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_wr", 32'(fifo_write), 32'd0);
            else check("stream_data", 32'(fifo_wrdata), 32'(vdata(exp_q.pop_front())));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic lp);
        enable = 1'b0;
        tick();
        tick();
        start_addr = s;
        end_addr   = e;
        loop_en    = lp;
        enable     = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vram_req !== 1'b1 && n < budget);
        check("req_seen", 32'(vram_req), 32'd1);
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vram_ack !== 1'b1 && n < budget);
        check("ack_seen", 32'(vram_ack), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < budget);
        check("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; loop_en = 1'b0; start_addr = '0; end_addr = '0;
        fifo_reset = 1'b0; cpu_wrdata = 8'h00; cpu_write = 1'b0; fifo_full = 1'b0;
        fifo_almost_empty = 1'b0;

        // Reset state, plus CPU passthrough while still in reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vram_req", 32'(vram_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fifo_write", 32'(fifo_write), 32'd0);
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        tick();
        cpu_write = 1'b1; cpu_wrdata = 8'h33; cpu_q.push_back(8'h33);
        tick();
        cpu_write = 1'b0; rst = 1'b0;

        // 16-byte burst, then idle, then the next burst resumes at 0x110.
        fifo_almost_empty = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(17'h00100 + AW'(i));
        start_stream(17'h00100, 17'h001FF, 1'b0);
        wait_drain(400);
        @(negedge clk);
        check("burst_end_busy", 32'(busy), 32'd0);
        check("burst_end_req", 32'(vram_req), 32'd0);
        wait_req(20);
        check("next_burst_addr", 32'(vram_addr), 32'h110);
        tick();
        enable = 1'b0;
        wait_idle(20);

        // CPU write lands while the feeder holds 0x5A in WRITE.
        done_base = done_cnt;
        exp_q.push_back(17'h0005A);
        exp_q.push_back(17'h0005B);
        start_stream(17'h0005A, 17'h0005B, 1'b0);
        wait_ack(40);
        tick();
        cpu_write = 1'b1; cpu_wrdata = 8'hC3; cpu_q.push_back(8'hC3);
        tick();
        cpu_write = 1'b0;
        wait_drain(100);
        repeat (3) @(negedge clk);
        check("cpu_prio_done", 32'(done_cnt - done_base), 32'd1);

        // Non-looping end: one done pulse, then quiet.
        done_base = done_cnt;
        exp_q.push_back(17'h10); exp_q.push_back(17'h11); exp_q.push_back(17'h12);
        start_stream(17'h00010, 17'h00012, 1'b0);
        wait_drain(100);
        repeat (5) @(negedge clk);
        check("end_done_once", 32'(done_cnt - done_base), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_no_req", 32'(vram_req), 32'd0);

        // Looping: wraps back to start, never signals done.
        done_base = done_cnt;
        for (int i = 0; i < 7; i++) exp_q.push_back(17'h10 + AW'(i % 3));
        start_stream(17'h00010, 17'h00012, 1'b1);
        wait_drain(200);
        enable = 1'b0;
        wait_idle(20);
        repeat (2) @(negedge clk);
        check("loop_no_done", 32'(done_cnt - done_base), 32'd0);

        // Address wrap across 2^17.
        done_base = done_cnt;
        exp_q.push_back(17'h1FFFE); exp_q.push_back(17'h1FFFF);
        exp_q.push_back(17'h00000); exp_q.push_back(17'h00001);
        start_stream(17'h1FFFE, 17'h00001, 1'b0);
        wait_drain(100);
        wait_idle(20);
        repeat (2) @(negedge clk);
        check("wrap_done", 32'(done_cnt - done_base), 32'd1);

        // fifo_reset during a slow request: request held to ack, data dropped.
        lat = 5;
        start_stream(17'h00030, 17'h0003F, 1'b0);
        wait_req(20);
        tick();
        fifo_reset = 1'b1; fifo_almost_empty = 1'b0;
        tick();
        fifo_reset = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                check("abort_req_held", 32'(vram_req), 32'd1);
                n++;
            end while (vram_ack !== 1'b1 && n < 20);
        end
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_drop", 32'(vram_req), 32'd0);
        lat = 2;

        // enable dropped while in WRITE: no write.
        fifo_almost_empty = 1'b1;
        start_stream(17'h00040, 17'h0004F, 1'b0);
        wait_ack(40);
        tick();
        enable = 1'b0;
        @(negedge clk);
        check("disable_no_wr", 32'(fifo_write), 32'd0);
        wait_idle(20);
        repeat (4) @(negedge clk);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
